// File: rtl/prf_rd_arb_if.sv
// PRF read-port arbiter bus: requester side plus the PRF read-port pair.
// master = requesters and PRF model, slave = arbiter.
interface prf_rd_arb_if #(
  parameter int NUM_REQ  = 3,
  parameter int PRF_ID_W = 7,
  parameter int DATA_W   = 64
) ();
  logic [NUM_REQ-1:0]                     req_rd0;
  logic [NUM_REQ-1:0][1:0]                req_rden_rd0;
  logic [NUM_REQ-1:0][1:0][PRF_ID_W-1:0]  req_rdaddr_rd0;
  logic [NUM_REQ-1:0]                     gnt_rd0;
  logic [1:0]                             prf_rdens_rd0;
  logic [1:0][PRF_ID_W-1:0]               prf_rdaddrs_rd0;
  logic [1:0][DATA_W-1:0]                 prf_rddatas_rd1;
  logic [NUM_REQ-1:0]                     rsp_vld_rd1;
  logic [1:0][DATA_W-1:0]                 rsp_data_rd1;
  logic [NUM_REQ-1:0]                     starved;

  modport master (
    output req_rd0,
    output req_rden_rd0,
    output req_rdaddr_rd0,
    output prf_rddatas_rd1,
    input  gnt_rd0,
    input  prf_rdens_rd0,
    input  prf_rdaddrs_rd0,
    input  rsp_vld_rd1,
    input  rsp_data_rd1,
    input  starved
  );

  modport slave (
    input  req_rd0,
    input  req_rden_rd0,
    input  req_rdaddr_rd0,
    input  prf_rddatas_rd1,
    output gnt_rd0,
    output prf_rdens_rd0,
    output prf_rdaddrs_rd0,
    output rsp_vld_rd1,
    output rsp_data_rd1,
    output starved
  );
endinterface

// File: rtl/prf_rd_arb.sv
// Round-robin PRF read-port arbiter with starvation override and a
// one-stage response pipeline that tags returning data with its owner.
module prf_rd_arb #(
  parameter int NUM_REQ    = 3,
  parameter int PRF_ID_W   = 7,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 7
) (
  input  logic         clk,
  input  logic         reset,
  prf_rd_arb_if.slave  bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]        rr_q, rr_d;
  logic [NUM_REQ-1:0][3:0] wait_q, wait_d;
  logic [NUM_REQ-1:0]      vld_q, vld_d;
  logic [1:0]              en_q, en_d;

  logic [NUM_REQ-1:0]      starved_q;
  logic [NUM_REQ-1:0]      hit;
  logic [NUM_REQ-1:0]      gnt;
  logic [PTR_W-1:0]        st_idx, rr_idx, gidx;
  logic                    st_any, rr_any, gany;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      starved_q[i] = (wait_q[i] == SMAX);
    end
  end

  assign hit = bus.req_rd0 & starved_q;

  // Descending scans let the first match in priority order win last.
  always_comb begin
    st_idx = '0;
    st_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (hit[i]) begin
        st_idx = PTR_W'(i);
        st_any = 1'b1;
      end
    end
  end

  always_comb begin
    int j;
    rr_idx = '0;
    rr_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(rr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (bus.req_rd0[j]) begin
        rr_idx = PTR_W'(j);
        rr_any = 1'b1;
      end
    end
  end

  always_comb begin
    gidx = st_any ? st_idx : rr_idx;
    gany = (st_any | rr_any) & ~reset;
    gnt  = '0;
    gnt[gidx] = gany;
  end

  always_comb begin
    en_d = '0;
    bus.prf_rdaddrs_rd0 = '0;
    if (gany) begin
      en_d = bus.req_rden_rd0[gidx];
      bus.prf_rdaddrs_rd0 = bus.req_rdaddr_rd0[gidx];
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (gany) begin
      if (gidx == LAST) rr_d = '0;
      else              rr_d = gidx + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      wait_d[i] = wait_q[i];
      if (!bus.req_rd0[i] || gnt[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != SMAX) begin
        wait_d[i] = wait_q[i] + 4'd1;
      end
    end
  end

  assign vld_d = gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q   <= '0;
      wait_q <= '0;
      vld_q  <= '0;
      en_q   <= '0;
    end else begin
      rr_q   <= rr_d;
      wait_q <= wait_d;
      vld_q  <= vld_d;
      en_q   <= en_d;
    end
  end

  // Reset masks the rd1 stage so an in-flight grant never returns.
  always_comb begin
    bus.gnt_rd0       = gnt;
    bus.prf_rdens_rd0 = en_d;
    bus.rsp_vld_rd1   = reset ? '0 : vld_q;
    bus.starved       = reset ? '0 : starved_q;
    for (int p = 0; p < 2; p++) begin
      bus.rsp_data_rd1[p] = (!reset && en_q[p]) ?
                            bus.prf_rddatas_rd1[p] : '0;
    end
  end
endmodule

// File: tb/tb_prf_rd_arb.sv
// Scoreboard bench for prf_rd_arb: directed vectors push expectations,
// a negedge monitor pops and compares grants and responses.
module tb_prf_rd_arb;
  localparam int N  = 3;
  localparam int AW = 7;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  prf_rd_arb_if #(.NUM_REQ(N), .PRF_ID_W(AW), .DATA_W(DW)) bus ();

  prf_rd_arb #(
    .NUM_REQ(N), .PRF_ID_W(AW), .DATA_W(DW), .STARVE_MAX(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  typedef struct packed {
    logic [N-1:0]        gnt;
    logic [1:0]          en;
    logic [1:0][AW-1:0]  a;
  } gexp_t;

  typedef struct packed {
    logic [N-1:0]        vld;
    logic [1:0][DW-1:0]  d;
  } rexp_t;

  int tests = 0;
  int fails = 0;
  gexp_t gq[$];
  rexp_t rq[$];
  gexp_t ge;
  rexp_t re;
  bit sb_en = 1'b1;
  logic [N-1:0] prev_gnt = '0;
  logic [1:0][AW-1:0] atbl [N];

  function automatic logic [DW-1:0] f(input int p, input logic [AW-1:0] a);
    return {32'hD00D_0000 | 32'(p), 25'd0, a};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // PRF model: data returns one cycle after the address is presented.
  always @(posedge clk) begin
    bus.prf_rddatas_rd1 <= {f(1, bus.prf_rdaddrs_rd0[1]),
                            f(0, bus.prf_rdaddrs_rd0[0])};
  end

  always @(negedge clk) begin
    if (sb_en && bus.gnt_rd0 != '0) begin
      if (gq.size() == 0) begin
        chk("gnt_unexpected", 128'(bus.gnt_rd0), 128'(0));
      end else begin
        ge = gq.pop_front();
        chk("gnt", 128'(bus.gnt_rd0), 128'(ge.gnt));
        chk("prf_rdens", 128'(bus.prf_rdens_rd0), 128'(ge.en));
        chk("prf_rdaddrs", 128'(bus.prf_rdaddrs_rd0), 128'(ge.a));
      end
    end
    if (sb_en && bus.rsp_vld_rd1 != '0) begin
      if (rq.size() == 0) begin
        chk("rsp_unexpected", 128'(bus.rsp_vld_rd1), 128'(0));
      end else begin
        re = rq.pop_front();
        chk("rsp_vld", 128'(bus.rsp_vld_rd1), 128'(re.vld));
        chk("rsp_data", 128'(bus.rsp_data_rd1), 128'(re.d));
      end
    end
    chk("vld_delay", 128'(bus.rsp_vld_rd1),
        reset ? 128'(0) : 128'(prev_gnt));
    chk("gnt_onehot0", 128'($onehot0(bus.gnt_rd0)), 128'(1));
    chk("gnt_subset", 128'(bus.gnt_rd0 & ~bus.req_rd0), 128'(0));
    if (!reset && bus.req_rd0 != '0) begin
      chk("no_bubble", 128'(bus.gnt_rd0 != '0), 128'(1));
    end
    prev_gnt <= bus.gnt_rd0;
  end

  task automatic step(input logic [N-1:0] req,
                      input logic [N-1:0][1:0] en,
                      input logic [N-1:0] eg,
                      input bit rsp = 1'b1);
    bus.req_rd0      = req;
    bus.req_rden_rd0 = en;
    if (eg != '0) begin
      int g;
      gexp_t x;
      rexp_t y;
      g = eg[0] ? 0 : (eg[1] ? 1 : 2);
      x.gnt = eg;
      x.en  = en[g];
      x.a   = atbl[g];
      gq.push_back(x);
      if (rsp) begin
        y.vld  = eg;
        y.d[0] = en[g][0] ? f(0, atbl[g][0]) : '0;
        y.d[1] = en[g][1] ? f(1, atbl[g][1]) : '0;
        rq.push_back(y);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    reset = 1'b1;
    bus.req_rd0      = '1;
    bus.req_rden_rd0 = '1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_gnt", 128'(bus.gnt_rd0), 128'(0));
      chk("rst_prf", 128'({bus.prf_rdens_rd0, bus.prf_rdaddrs_rd0}),
          128'(0));
      chk("rst_rsp", 128'({bus.rsp_vld_rd1, bus.rsp_data_rd1}),
          128'(0));
      chk("rst_starved", 128'(bus.starved), 128'(0));
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    bus.req_rd0 = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    atbl[0] = {7'd4, 7'd3};
    atbl[1] = {7'd9, 7'd5};
    atbl[2] = {7'd17, 7'd12};
    for (int i = 0; i < N; i++) bus.req_rdaddr_rd0[i] = atbl[i];
    bus.req_rd0      = '0;
    bus.req_rden_rd0 = '0;

    do_rst();
    step(3'b111, 6'b111111, 3'b001);
    step(3'b111, 6'b111111, 3'b010);
    step(3'b111, 6'b111111, 3'b100);
    step(3'b111, 6'b111111, 3'b001);
    step(3'b111, 6'b111111, 3'b010);
    step(3'b111, 6'b111111, 3'b100);
    step(3'b000, 6'b000000, 3'b000);

    do_rst();
    step(3'b010, 6'b001100, 3'b010);
    step(3'b000, 6'b000000, 3'b000);
    step(3'b001, 6'b000001, 3'b001);
    step(3'b100, 6'b000000, 3'b100);
    step(3'b000, 6'b000000, 3'b000);

    step(3'b101, 6'b111111, 3'b001);
    chk("starved_s1", 128'(bus.starved), 128'(3'b000));
    step(3'b111, 6'b111111, 3'b010);
    chk("starved_s2", 128'(bus.starved), 128'(3'b100));
    step(3'b100, 6'b111111, 3'b100);
    chk("starved_clr", 128'(bus.starved), 128'(3'b000));
    step(3'b000, 6'b000000, 3'b000);

    step(3'b010, 6'b111111, 3'b010, 1'b0);
    do_rst();
    step(3'b111, 6'b111111, 3'b001);
    step(3'b111, 6'b111111, 3'b010);
    step(3'b000, 6'b000000, 3'b000);

    sb_en = 1'b0;
    for (int c = 0; c < 60; c++) begin
      bus.req_rd0      = 3'($urandom_range(0, 7));
      bus.req_rden_rd0 = 6'($urandom);
      @(posedge clk);
      #1;
    end
    step(3'b000, 6'b000000, 3'b000);
    step(3'b000, 6'b000000, 3'b000);
    sb_en = 1'b1;
    step(3'b000, 6'b000000, 3'b000);

    chk("gq_empty", 128'(gq.size()), 128'(0));
    chk("rq_empty", 128'(rq.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/prf_rd_arb.md
PRF_RD_ARB -- requirements
Module: prf_rd_arb

Interface
REQ-001 Parameter NUM_REQ, default 3: number of reservation-station requesters sharing the PRF read-port pair.
REQ-002 Parameter PRF_ID_W, default 7: physical register id width.
REQ-003 Parameter DATA_W, default 64: register data width.
REQ-004 Parameter STARVE_MAX, default 7: wait-count threshold for starvation priority; legal range 1..15.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req_rd0  input  NUM_REQ  per-requester request for both PRF read ports this cycle.
REQ-008 req_rden_rd0  input  NUM_REQ x 2  per-requester port enables, [0]=src1, [1]=src2.
REQ-009 req_rdaddr_rd0  input  NUM_REQ x 2 x PRF_ID_W  per-requester read addresses.
REQ-010 gnt_rd0  output  NUM_REQ  one-hot-or-zero grant, same cycle as request.
REQ-011 prf_rdens_rd0  output  2  read enables to PRF.
REQ-012 prf_rdaddrs_rd0  output  2 x PRF_ID_W  read addresses to PRF.
REQ-013 prf_rddatas_rd1  input  2 x DATA_W  PRF read data, one cycle after rd0.
REQ-014 rsp_vld_rd1  output  NUM_REQ  one-hot-or-zero: data for requester i valid this cycle.
REQ-015 rsp_data_rd1  output  2 x DATA_W  read data broadcast to all requesters; qualified by rsp_vld_rd1.
REQ-016 starved  output  NUM_REQ  requester i wait count has reached STARVE_MAX.

Function
REQ-017 At most one requester granted per cycle; granted requester owns both PRF ports that cycle.
REQ-018 gnt_rd0[i] only when req_rd0[i]=1; any cycle with req_rd0!=0 grants exactly one requester (no idle bubble).
REQ-019 Normal priority round-robin: search starts at rr_ptr, wraps from NUM_REQ-1 to 0; first requesting index wins.
REQ-020 Starvation override: if any requesting i has starved[i]=1, lowest-index starved requester wins, ignoring rr_ptr.
REQ-021 On any grant to index g, rr_ptr <= (g+1) mod NUM_REQ next cycle; no grant leaves rr_ptr unchanged.
REQ-022 prf_rdens_rd0 = req_rden_rd0[g] and prf_rdaddrs_rd0 = req_rdaddr_rd0[g] for granted g; with no grant, enables 0 and addresses 0.
REQ-023 Per-requester wait counter, 4 bits: +1 (saturating at STARVE_MAX) each cycle req=1 and gnt=0; cleared on grant or when req=0.
REQ-024 starved[i] = (wait[i] == STARVE_MAX), registered state, not combinational on current request.
REQ-025 Grant tag pipelined one stage: rsp_vld_rd1 = gnt_rd0 delayed one cycle; no other latency.
REQ-026 rsp_data_rd1[p] = prf_rddatas_rd1[p] when the delayed enable for port p was 1, else 0.
REQ-027 Back-to-back grants to the same or different requesters every cycle fully supported; throughput 1 grant/cycle.
REQ-028 Requester not granted holds its request; block imposes no drop and needs no retry protocol.
REQ-029 req_rd0[i]=1 with req_rden_rd0[i]=0 is legal: granted, consumes slot, returns rsp_vld with zero data.

Reset
REQ-030 During reset: gnt_rd0=0, prf_rdens_rd0=0, prf_rdaddrs_rd0=0, rsp_vld_rd1=0, rsp_data_rd1=0, starved=0, regardless of inputs.
REQ-031 Reset sets rr_ptr=0, all wait counters=0, grant pipeline stage=0.
REQ-032 Reset asserted while a grant is in rd0 kills the rd1 response: rsp_vld_rd1=0 in the cycle after reset.
REQ-033 First cycle after reset deasserts, arbitration starts at index 0.

Verification
REQ-034 Single: after reset, req_rd0=3'b010, rden=2'b11, addrs 5/9 -> gnt=3'b010, prf addrs 5/9; next cycle rsp_vld=3'b010, data = PRF data.
REQ-035 Round-robin: req_rd0=3'b111 held 6 cycles -> grants 001,010,100,001,010,100.
REQ-036 Partial enable: requester 0 rden=2'b01 -> prf_rdens_rd0=2'b01; next cycle rsp_data_rd1[1]=0.
REQ-037 Starvation: STARVE_MAX=2, requester 2 held high, rr forced to favor 0/1 by pulsing -> after 2 losses starved[2]=1 and requester 2 wins next cycle, wait[2] cleared.
REQ-038 Reset mid-flight: grant to requester 1 at cycle N, reset at N+1 -> rsp_vld_rd1=0 at N+1, rr_ptr=0 after release.
REQ-039 Random: assert gnt one-hot-or-zero, gnt subset of req, no idle bubble, rsp_vld equals gnt delayed 1, no wait count exceeds STARVE_MAX.
